wb_arbiter: RTL and testbench

Parametrised multi-source writeback unit. It replaces the single-source, purely combinational writeback select with per-source buffering and arbitration.
- Accepts results from NUM_SRC producers (e.g. ALU/PC+4 path, LSU, multiply/divide unit) via valid/ready handshakes.
- Buffers each source in a small FIFO and arbitrates one register-file write per cycle.
- Exports a pending-destination bitmap so the hazard unit can stall readers of in-flight registers.

---
 rtl/wb_arbiter_pkg.sv | 16 +
 rtl/wb_fifo.sv | 63 ++++++
 rtl/wb_arbiter.sv | 128 ++++++++++++
 tb/tb_wb_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the multi-source writeback arbiter.
// wb_entry_t is the default-width entry; the top rebuilds it for other XLEN values.
package wb_arbiter_pkg;

   localparam int REG_ADDR_W   = 5;
   localparam int XLEN_DEFAULT = 32;

   localparam int ARB_RR    = 0;
   localparam int ARB_FIXED = 1;

   typedef struct packed {
      logic [REG_ADDR_W-1:0]   rd;
      logic [XLEN_DEFAULT-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Per-source result FIFO; also exposes every slot's rd and occupancy so the
// arbiter can build the pending-destination bitmap.
module wb_fifo
   import wb_arbiter_pkg::*;
#(
   parameter type entry_t = wb_entry_t,
   parameter int  DEPTH   = 2
) (
   input  logic                                clk,
   input  logic                                arst_n,
   input  logic                                push,
   input  entry_t                              push_entry,
   input  logic                                pop,
   output entry_t                              head,
   output logic                                full,
   output logic                                empty,
   output logic [DEPTH-1:0][REG_ADDR_W-1:0]    slot_rd,
   output logic [DEPTH-1:0]                    slot_vld
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   entry_t           mem [DEPTH];

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
      end
   end

   // Storage carries no reset; occupancy is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_entry;
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   always_comb begin
      logic [PTR_W-1:0] offset;
      slot_rd  = '0;
      slot_vld = '0;
      offset   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset      = PTR_W'(i) - rd_ptr;
         slot_vld[i] = ({1'b0, offset} < count);
         slot_rd[i]  = mem[i].rd;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Multi-source writeback: buffers results per source, arbitrates one
// register-file write per cycle and reports in-flight destinations.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int NUM_SRC   = 3,
   parameter int BUF_DEPTH = 2,
   parameter int ARB_MODE  = ARB_RR
) (
   input  logic                         clk,
   input  logic                         arst_n,
   input  logic [NUM_SRC-1:0]           src_valid,
   output logic [NUM_SRC-1:0]           src_ready,
   input  logic [NUM_SRC*5-1:0]         src_rd,
   input  logic [NUM_SRC*XLEN-1:0]      src_data,
   output logic                         rf_en,
   output logic [REG_ADDR_W-1:0]        rf_rd,
   output logic [XLEN-1:0]              rf_wdata,
   output logic [31:0]                  pend_mask,
   output logic                         busy
);

   localparam int SRC_W = $clog2(NUM_SRC);

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } entry_t;

   entry_t                                   push_entry [NUM_SRC];
   entry_t                                   head       [NUM_SRC];
   logic [NUM_SRC-1:0]                       full;
   logic [NUM_SRC-1:0]                       empty;
   logic [NUM_SRC-1:0]                       push;
   logic [NUM_SRC-1:0]                       pop;
   logic [BUF_DEPTH-1:0][REG_ADDR_W-1:0]     slot_rd    [NUM_SRC];
   logic [BUF_DEPTH-1:0]                     slot_vld   [NUM_SRC];

   logic                                     grant_vld_p0;
   logic [SRC_W-1:0]                         winner_p0;
   entry_t                                   win_head_p0;
   logic [SRC_W-1:0]                         rr_ptr;

   logic                                     rf_en_p1;
   logic [REG_ADDR_W-1:0]                    rf_rd_p1;
   logic [XLEN-1:0]                          rf_wdata_p1;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      assign push[g]            = src_valid[g] && !full[g];
      assign pop[g]             = grant_vld_p0 && (winner_p0 == SRC_W'(g));
      assign push_entry[g].rd   = src_rd[5*g +: 5];
      assign push_entry[g].data = src_data[XLEN*g +: XLEN];

      wb_fifo #(
         .entry_t (entry_t),
         .DEPTH   (BUF_DEPTH)
      ) u_fifo (
         .clk        (clk),
         .arst_n     (arst_n),
         .push       (push[g]),
         .push_entry (push_entry[g]),
         .pop        (pop[g]),
         .head       (head[g]),
         .full       (full[g]),
         .empty      (empty[g]),
         .slot_rd    (slot_rd[g]),
         .slot_vld   (slot_vld[g])
      );
   end

   // Stage p0: pick one FIFO head; round-robin starts just after the last winner.
   always_comb begin
      logic [SRC_W:0] idx;
      grant_vld_p0 = 1'b0;
      winner_p0    = '0;
      idx          = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (ARB_MODE == ARB_FIXED) begin
            idx = (SRC_W+1)'(k);
         end else begin
            idx = {1'b0, rr_ptr} + (SRC_W+1)'(k + 1);
            if (idx >= (SRC_W+1)'(NUM_SRC)) idx = idx - (SRC_W+1)'(NUM_SRC);
         end
         if (!grant_vld_p0 && !empty[idx]) begin
            grant_vld_p0 = 1'b1;
            winner_p0    = idx[SRC_W-1:0];
         end
      end
   end

   assign win_head_p0 = head[winner_p0];

   // Stage p1: registered register-file write; rd=0 grants are consumed silently.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         rf_en_p1    <= 1'b0;
         rf_rd_p1    <= '0;
         rf_wdata_p1 <= '0;
         rr_ptr      <= SRC_W'(NUM_SRC - 1);
      end else begin
         rf_en_p1 <= grant_vld_p0 && (win_head_p0.rd != '0);
         if (grant_vld_p0) begin
            rf_rd_p1    <= win_head_p0.rd;
            rf_wdata_p1 <= win_head_p0.data;
            rr_ptr      <= winner_p0;
         end
      end
   end

   assign rf_en     = rf_en_p1;
   assign rf_rd     = rf_rd_p1;
   assign rf_wdata  = rf_wdata_p1;
   assign src_ready = ~full;
   assign busy      = !(&empty) || rf_en_p1;

   always_comb begin
      pend_mask = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         for (int b = 0; b < BUF_DEPTH; b++) begin
            if (slot_vld[s][b]) pend_mask[slot_rd[s][b]] = 1'b1;
         end
      end
      if (rf_en_p1) pend_mask[rf_rd_p1] = 1'b1;
      pend_mask[0] = 1'b0;
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: one round-robin and one fixed-priority
// instance share the same source stimulus.
module tb_wb_arbiter;

   localparam int XLEN = 32;
   localparam int NSRC = 3;

   logic              clk;
   logic              arst_n;
   logic [NSRC-1:0]   src_valid;
   logic [NSRC*5-1:0] src_rd;
   logic [NSRC*XLEN-1:0] src_data;

   logic [NSRC-1:0]   rr_ready,  fx_ready;
   logic              rr_rf_en,  fx_rf_en;
   logic [4:0]        rr_rf_rd,  fx_rf_rd;
   logic [XLEN-1:0]   rr_wdata,  fx_wdata;
   logic [31:0]       rr_pend,   fx_pend;
   logic              rr_busy,   fx_busy;

   int checks   = 0;
   int failures = 0;

   wb_arbiter #(.XLEN(XLEN), .NUM_SRC(NSRC), .BUF_DEPTH(2), .ARB_MODE(0)) u_rr (
      .clk(clk), .arst_n(arst_n), .src_valid(src_valid), .src_ready(rr_ready),
      .src_rd(src_rd), .src_data(src_data), .rf_en(rr_rf_en), .rf_rd(rr_rf_rd),
      .rf_wdata(rr_wdata), .pend_mask(rr_pend), .busy(rr_busy));

   wb_arbiter #(.XLEN(XLEN), .NUM_SRC(NSRC), .BUF_DEPTH(2), .ARB_MODE(1)) u_fx (
      .clk(clk), .arst_n(arst_n), .src_valid(src_valid), .src_ready(fx_ready),
      .src_rd(src_rd), .src_data(src_data), .rf_en(fx_rf_en), .rf_rd(fx_rf_rd),
      .rf_wdata(fx_wdata), .pend_mask(fx_pend), .busy(fx_busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
      src_valid[i]        = v;
      src_rd[i*5 +: 5]    = rd;
      src_data[i*32 +: 32] = d;
   endtask

   task automatic do_reset();
      src_valid = '0;
      src_rd    = '0;
      src_data  = '0;
      arst_n    = 1'b0;
      tick();
      arst_n    = 1'b1;
   endtask

   task automatic test_reset();
      src_valid = '0;
      src_rd    = '0;
      src_data  = '0;
      arst_n    = 1'b0;
      #2;
      checks++;
      if ({rr_rf_en, rr_rf_rd, rr_wdata, rr_pend, rr_busy} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: rf_en=%0b rf_rd=%0d wdata=%h pend=%h busy=%0b, required all zero",
                  rr_rf_en, rr_rf_rd, rr_wdata, rr_pend, rr_busy);
      end
      checks++;
      if (rr_ready !== 3'b111 || fx_ready !== 3'b111) begin
         failures++;
         $display("FAIL reset_ready: rr=%b fx=%b, required 111", rr_ready, fx_ready);
      end
      tick();
      arst_n = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      set_src(0, 1'b1, 5'd5, 32'hDEADBEEF);
      tick();                                   // E0 accept
      src_valid = '0;
      checks++;
      if (rr_rf_en !== 1'b0 || rr_pend !== 32'h20 || rr_busy !== 1'b1) begin
         failures++;
         $display("FAIL single_buffered: rf_en=%0b pend=%h busy=%0b, required 0 00000020 1",
                  rr_rf_en, rr_pend, rr_busy);
      end
      tick();                                   // E1 grant
      checks++;
      if (rr_rf_en !== 1'b1 || rr_rf_rd !== 5'd5 || rr_wdata !== 32'hDEADBEEF || rr_pend !== 32'h20) begin
         failures++;
         $display("FAIL single_write: rf_en=%0b rd=%0d wdata=%h pend=%h, required 1 5 deadbeef 00000020",
                  rr_rf_en, rr_rf_rd, rr_wdata, rr_pend);
      end
      tick();
      checks++;
      if (rr_rf_en !== 1'b0 || rr_pend !== 32'h0 || rr_busy !== 1'b0 || rr_rf_rd !== 5'd5) begin
         failures++;
         $display("FAIL single_idle: rf_en=%0b pend=%h busy=%0b rd=%0d, required 0 0 0 5 (held)",
                  rr_rf_en, rr_pend, rr_busy, rr_rf_rd);
      end
   endtask

   task automatic test_round_robin();
      logic [4:0] exp;
      bit         drained;
      do_reset();
      for (int i = 0; i < NSRC; i++) set_src(i, 1'b1, 5'(i + 1), 32'hA0 + i);
      tick();                                   // E0: all three accepted
      for (int n = 1; n <= 6; n++) begin
         tick();
         exp = 5'((n - 1) % 3 + 1);
         checks++;
         if (rr_rf_en !== 1'b1 || rr_rf_rd !== exp) begin
            failures++;
            $display("FAIL rr_order[%0d]: rf_en=%0b rd=%0d, required 1 %0d", n, rr_rf_en, rr_rf_rd, exp);
         end
         if (n == 1) begin
            checks++;
            if (rr_ready !== 3'b001) begin
               failures++;
               $display("FAIL rr_backpressure: ready=%b, required 001", rr_ready);
            end
         end
      end
      src_valid = '0;
      drained = 1'b0;
      for (int c = 0; c < 20 && !drained; c++) begin
         tick();
         if (!rr_busy) drained = 1'b1;
      end
      checks++;
      if (!drained) begin
         failures++;
         $display("FAIL rr_drain: busy=%0b after 20 cycles, required 0", rr_busy);
      end
   endtask

   task automatic test_fixed_priority();
      logic [4:0] seq [5] = '{5'd1, 5'd2, 5'd2, 5'd3, 5'd3};
      do_reset();
      for (int i = 0; i < NSRC; i++) set_src(i, 1'b1, 5'(i + 1), 32'hB0 + i);
      tick();                                   // E0
      for (int n = 1; n <= 4; n++) begin
         tick();
         checks++;
         if (fx_rf_en !== 1'b1 || fx_rf_rd !== 5'd1) begin
            failures++;
            $display("FAIL fx_src0_only[%0d]: rf_en=%0b rd=%0d, required 1 1", n, fx_rf_en, fx_rf_rd);
         end
         if (n == 2) begin
            checks++;
            if (fx_ready !== 3'b001) begin
               failures++;
               $display("FAIL fx_stall: ready=%b, required 001", fx_ready);
            end
         end
      end
      src_valid = '0;
      for (int n = 0; n < 5; n++) begin
         tick();
         checks++;
         if (fx_rf_en !== 1'b1 || fx_rf_rd !== seq[n]) begin
            failures++;
            $display("FAIL fx_drain[%0d]: rf_en=%0b rd=%0d, required 1 %0d", n, fx_rf_en, fx_rf_rd, seq[n]);
         end
      end
      tick();
      checks++;
      if (fx_rf_en !== 1'b0 || fx_busy !== 1'b0) begin
         failures++;
         $display("FAIL fx_idle: rf_en=%0b busy=%0b, required 0 0", fx_rf_en, fx_busy);
      end
   endtask

   task automatic test_rd_zero();
      do_reset();
      set_src(1, 1'b1, 5'd0, 32'h1234);
      tick();                                   // E0
      src_valid = '0;
      checks++;
      if (rr_pend !== 32'h0 || rr_busy !== 1'b1) begin
         failures++;
         $display("FAIL rd0_buffered: pend=%h busy=%0b, required 0 1", rr_pend, rr_busy);
      end
      tick();                                   // E1: rd=0 consumes the grant
      checks++;
      if (rr_rf_en !== 1'b0 || rr_pend !== 32'h0 || rr_wdata !== 32'h1234) begin
         failures++;
         $display("FAIL rd0_consumed: rf_en=%0b pend=%h wdata=%h, required 0 0 00001234",
                  rr_rf_en, rr_pend, rr_wdata);
      end
      set_src(0, 1'b1, 5'd4, 32'h44);
      set_src(2, 1'b1, 5'd6, 32'h66);
      tick();                                   // E2 accept both
      src_valid = '0;
      tick();                                   // pointer at 1, so source 2 wins first
      checks++;
      if (rr_rf_en !== 1'b1 || rr_rf_rd !== 5'd6) begin
         failures++;
         $display("FAIL rd0_ptr_first: rf_en=%0b rd=%0d, required 1 6", rr_rf_en, rr_rf_rd);
      end
      tick();
      checks++;
      if (rr_rf_en !== 1'b1 || rr_rf_rd !== 5'd4) begin
         failures++;
         $display("FAIL rd0_ptr_second: rf_en=%0b rd=%0d, required 1 4", rr_rf_en, rr_rf_rd);
      end
   endtask

   task automatic test_blocked_source();
      logic [4:0] seq [3] = '{5'd9, 5'd7, 5'd8};
      do_reset();
      set_src(0, 1'b1, 5'd9, 32'h99);
      set_src(2, 1'b1, 5'd7, 32'h77);
      tick();                                   // E0
      set_src(2, 1'b1, 5'd8, 32'h88);
      tick();                                   // E1: source 2 now full
      set_src(2, 1'b0, 5'd8, 32'h88);
      checks++;
      if (fx_ready[2] !== 1'b0 || fx_pend !== 32'h380) begin
         failures++;
         $display("FAIL blk_full: ready2=%0b pend=%h, required 0 00000380", fx_ready[2], fx_pend);
      end
      tick();                                   // E2
      checks++;
      if (fx_rf_rd !== 5'd9 || fx_ready[2] !== 1'b0) begin
         failures++;
         $display("FAIL blk_hold: rd=%0d ready2=%0b, required 9 0", fx_rf_rd, fx_ready[2]);
      end
      src_valid = '0;
      for (int n = 0; n < 3; n++) begin
         tick();
         checks++;
         if (fx_rf_en !== 1'b1 || fx_rf_rd !== seq[n]) begin
            failures++;
            $display("FAIL blk_release[%0d]: rf_en=%0b rd=%0d, required 1 %0d", n, fx_rf_en, fx_rf_rd, seq[n]);
         end
      end
   endtask

   task automatic test_reset_mid_stream();
      do_reset();
      set_src(0, 1'b1, 5'd10, 32'hA);
      set_src(1, 1'b1, 5'd11, 32'hB);
      tick();                                   // E0
      src_valid = '0;
      tick();                                   // E1: rd 10 written, rd 11 still buffered
      checks++;
      if (rr_rf_en !== 1'b1 || rr_rf_rd !== 5'd10) begin
         failures++;
         $display("FAIL mid_pre: rf_en=%0b rd=%0d, required 1 10", rr_rf_en, rr_rf_rd);
      end
      #2;
      arst_n = 1'b0;
      #1;
      checks++;
      if (rr_rf_en !== 1'b0 || rr_pend !== 32'h0 || rr_busy !== 1'b0 || rr_ready !== 3'b111) begin
         failures++;
         $display("FAIL mid_reset: rf_en=%0b pend=%h busy=%0b ready=%b, required 0 0 0 111",
                  rr_rf_en, rr_pend, rr_busy, rr_ready);
      end
      tick();
      arst_n = 1'b1;
      for (int n = 0; n < 3; n++) begin
         tick();
         checks++;
         if (rr_rf_en !== 1'b0 || rr_busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_stale[%0d]: rf_en=%0b busy=%0b, required 0 0", n, rr_rf_en, rr_busy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_fixed_priority();
      test_rd_zero();
      test_blocked_source();
      test_reset_mid_stream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
